// File: rtl/vga_controller.sv
// rtl/vga_controller.sv - 640x480@60Hz VGA timing generator with RGB332 colour expansion
module vga_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rgb_8,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out,
    output logic       h_sync,
    output logic       v_sync,
    output logic       pixel_en
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VISIBLE    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VISIBLE    = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic       pix_tick;
    logic [9:0] hcount;
    logic [9:0] vcount;

    // pix_tick halves clk into the pixel rate; counters step only on its high phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_tick <= 1'b0;
            hcount   <= '0;
            vcount   <= '0;
        end else begin
            pix_tick <= ~pix_tick;
            if (pix_tick) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    if (vcount == V_LAST) begin
                        vcount <= '0;
                    end else begin
                        vcount <= vcount + 10'd1;
                    end
                end else begin
                    hcount <= hcount + 10'd1;
                end
            end
        end
    end

    assign h_sync   = ~((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
    assign v_sync   = ~((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
    assign pixel_en = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);

    // Colour is passed straight through; blanking is left to downstream logic
    assign r_out = {rgb_8[7:5], 5'b0};
    assign g_out = {rgb_8[4:2], 5'b0};
    assign b_out = {rgb_8[1:0], 6'b0};

endmodule

// File: tb/tb_vga_controller.sv
// tb/tb_vga_controller.sv - directed self-checking bench for vga_controller
module tb_vga_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rgb_8 = 8'h00;

    logic [7:0] r_out, g_out, b_out;
    logic       h_sync, v_sync, pixel_en;
    logic [7:0] s_r_out, s_g_out, s_b_out;
    logic       s_h_sync, s_v_sync, s_pixel_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    vga_controller dut (
        .clk      (clk),
        .rst      (rst),
        .rgb_8    (rgb_8),
        .r_out    (r_out),
        .g_out    (g_out),
        .b_out    (b_out),
        .h_sync   (h_sync),
        .v_sync   (v_sync),
        .pixel_en (pixel_en)
    );

    // Shrunk timing (16 px x 13 lines) so whole frames fit in a short run
    vga_controller #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) small_dut (
        .clk      (clk),
        .rst      (rst),
        .rgb_8    (rgb_8),
        .r_out    (s_r_out),
        .g_out    (s_g_out),
        .b_out    (s_b_out),
        .h_sync   (s_h_sync),
        .v_sync   (s_v_sync),
        .pixel_en (s_pixel_en)
    );

    task automatic measure_line(output int pe_fall, output int hs_fall, output int hs_rise,
                                output int pe_rise, output int hs_fall2, output int vs_low);
        pe_fall = -1; hs_fall = -1; hs_rise = -1; pe_rise = -1; hs_fall2 = -1; vs_low = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (pe_fall < 0 && pixel_en === 1'b0) pe_fall = n;
            else if (pe_fall >= 0 && pe_rise < 0 && pixel_en === 1'b1) pe_rise = n;
            if (hs_fall < 0 && h_sync === 1'b0) hs_fall = n;
            else if (hs_fall >= 0 && hs_rise < 0 && h_sync === 1'b1) hs_rise = n;
            else if (hs_rise >= 0 && hs_fall2 < 0 && h_sync === 1'b0) hs_fall2 = n;
            if (v_sync !== 1'b1) vs_low++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        rgb_8 = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++; if (h_sync !== 1'b1) begin n_fail++; $display("FAIL reset_h_sync: got %b expected 1", h_sync); end
        n_checks++; if (v_sync !== 1'b1) begin n_fail++; $display("FAIL reset_v_sync: got %b expected 1", v_sync); end
        n_checks++; if (pixel_en !== 1'b1) begin n_fail++; $display("FAIL reset_pixel_en: got %b expected 1", pixel_en); end
        n_checks++; if (s_v_sync !== 1'b1) begin n_fail++; $display("FAIL reset_small_v_sync: got %b expected 1", s_v_sync); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({r_out, g_out, b_out} !== 24'h000000) begin n_fail++; $display("FAIL reset_colour: got %h expected 000000", {r_out, g_out, b_out}); end
        n_checks++; if ({h_sync, v_sync, pixel_en} !== 3'b111) begin n_fail++; $display("FAIL post_release_timing: got %b expected 111", {h_sync, v_sync, pixel_en}); end
    endtask

    task automatic test_colour;
        logic [7:0] vin [4];
        logic [23:0] vexp [4];
        vin[0] = 8'hFF;       vexp[0] = 24'hE0E0C0;
        vin[1] = 8'b10101010; vexp[1] = 24'hA04080;
        vin[2] = 8'b01010101; vexp[2] = 24'h40A040;
        vin[3] = 8'b00011100; vexp[3] = 24'h00E000;
        for (int i = 0; i < 4; i++) begin
            rgb_8 = vin[i];
            #1;
            n_checks++;
            if ({r_out, g_out, b_out} !== vexp[i]) begin
                n_fail++;
                $display("FAIL colour_%0d: rgb_8=%h got %h expected %h", i, vin[i], {r_out, g_out, b_out}, vexp[i]);
            end
        end
        n_checks++;
        if ({s_r_out, s_g_out, s_b_out} !== 24'h00E000) begin
            n_fail++; $display("FAIL colour_small: got %h expected 00E000", {s_r_out, s_g_out, s_b_out});
        end
        rgb_8 = 8'h00;
    endtask

    task automatic test_line;
        int pe_fall, hs_fall, hs_rise, pe_rise, hs_fall2, vs_low;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        measure_line(pe_fall, hs_fall, hs_rise, pe_rise, hs_fall2, vs_low);
        n_checks++; if (pe_fall != 1280) begin n_fail++; $display("FAIL line_pixel_en_fall: got %0d expected 1280", pe_fall); end
        n_checks++; if (hs_fall != 1312) begin n_fail++; $display("FAIL line_h_sync_fall: got %0d expected 1312", hs_fall); end
        n_checks++; if (hs_rise != 1504) begin n_fail++; $display("FAIL line_h_sync_rise: got %0d expected 1504", hs_rise); end
        n_checks++; if (pe_rise != 1600) begin n_fail++; $display("FAIL line_pixel_en_rise: got %0d expected 1600", pe_rise); end
        n_checks++; if (hs_fall2 != 2912) begin n_fail++; $display("FAIL line_h_sync_fall2: got %0d expected 2912", hs_fall2); end
        n_checks++; if (vs_low != 0) begin n_fail++; $display("FAIL line_v_sync_low_cycles: got %0d expected 0", vs_low); end
    endtask

    task automatic test_frame;
        int vs_fall, vs_rise, vs_fall2, hs_fall, pe_blank, pe_frame;
        vs_fall = -1; vs_rise = -1; vs_fall2 = -1; hs_fall = -1; pe_blank = 0; pe_frame = 0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int n = 1; n <= 680; n++) begin
            @(negedge clk);
            if (vs_fall < 0 && s_v_sync === 1'b0) vs_fall = n;
            else if (vs_fall >= 0 && vs_rise < 0 && s_v_sync === 1'b1) vs_rise = n;
            else if (vs_rise >= 0 && vs_fall2 < 0 && s_v_sync === 1'b0) vs_fall2 = n;
            if (hs_fall < 0 && s_h_sync === 1'b0) hs_fall = n;
            if (n >= 192 && n < 416 && s_pixel_en === 1'b1) pe_blank++;
            if (n <= 416 && s_pixel_en === 1'b1) pe_frame++;
        end
        n_checks++; if (hs_fall != 20) begin n_fail++; $display("FAIL frame_h_sync_fall: got %0d expected 20", hs_fall); end
        n_checks++; if (vs_fall != 256) begin n_fail++; $display("FAIL frame_v_sync_fall: got %0d expected 256", vs_fall); end
        n_checks++; if (vs_rise != 320) begin n_fail++; $display("FAIL frame_v_sync_rise: got %0d expected 320", vs_rise); end
        n_checks++; if (vs_fall2 != 672) begin n_fail++; $display("FAIL frame_period: got %0d expected 672", vs_fall2); end
        n_checks++; if (pe_blank != 0) begin n_fail++; $display("FAIL frame_blank_lines_pixel_en: got %0d expected 0", pe_blank); end
        n_checks++; if (pe_frame != 96) begin n_fail++; $display("FAIL frame_visible_cycles: got %0d expected 96", pe_frame); end
        // At cycle 680 the small frame is on line 8, inside vertical sync
        n_checks++; if (s_v_sync !== 1'b0) begin n_fail++; $display("FAIL frame_in_vsync: got %b expected 0", s_v_sync); end
        #3 rst = 1'b0;
        #1;
        n_checks++; if ({s_h_sync, s_v_sync, s_pixel_en} !== 3'b111) begin n_fail++; $display("FAIL frame_async_reset: got %b expected 111", {s_h_sync, s_v_sync, s_pixel_en}); end
    endtask

    task automatic test_mid_reset;
        int pe_fall, hs_fall, hs_rise, pe_rise, hs_fall2, vs_low;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (1400) @(negedge clk);
        n_checks++; if ({h_sync, pixel_en} !== 2'b00) begin n_fail++; $display("FAIL mid_pre_reset: got %b expected 00", {h_sync, pixel_en}); end
        #3 rst = 1'b0;
        #1;
        n_checks++; if ({h_sync, v_sync, pixel_en} !== 3'b111) begin n_fail++; $display("FAIL mid_async_reset: got %b expected 111", {h_sync, v_sync, pixel_en}); end
        repeat (3) @(negedge clk);
        n_checks++; if ({h_sync, v_sync, pixel_en} !== 3'b111) begin n_fail++; $display("FAIL mid_reset_hold: got %b expected 111", {h_sync, v_sync, pixel_en}); end
        measure_line(pe_fall, hs_fall, hs_rise, pe_rise, hs_fall2, vs_low);
        n_checks++; if (pe_fall != 1280) begin n_fail++; $display("FAIL mid_restart_pixel_en_fall: got %0d expected 1280", pe_fall); end
        n_checks++; if (hs_fall != 1312) begin n_fail++; $display("FAIL mid_restart_h_sync_fall: got %0d expected 1312", hs_fall); end
        n_checks++; if (pe_rise != 1600) begin n_fail++; $display("FAIL mid_restart_line_period: got %0d expected 1600", pe_rise); end
    endtask

    initial begin
        test_reset();
        test_colour();
        test_line();
        test_frame();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
